audio_adc_rx_fifo: RTL

//  Parametrised audio ADC serial receiver; successor to the fixed stereo audio_interface input path.

---
 rtl/audio_adc_rx_fifo.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_adc_rx_fifo.sv
// Audio ADC serial receiver (I2S, left-justified or TDM) feeding a first-word-fall-through sample FIFO.
// Define AUDIO_RX_PEAK_EN to add the running |sample| peak detector (peak_level / peak_clr).
module audio_adc_rx_fifo #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_BITS  = 32,
  parameter int NUM_CH     = 2,
  parameter int MODE       = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STG   = 2,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int PTR_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       enable,
  input  logic                       adc_bclk,
  input  logic                       adc_lrck,
  input  logic                       adc_dat,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic [CH_W-1:0]            sample_ch,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [PTR_W-1:0]           fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
`ifdef AUDIO_RX_PEAK_EN
  ,
  output logic [SAMPLE_W-2:0]        peak_level,
  input  logic                       peak_clr
`endif
);

  localparam int CNT_W     = $clog2(SLOT_BITS + 1);
  localparam int IDX_W     = PTR_W - 1;
  localparam int FIRST_BIT = (MODE == 0) ? 1 : 0;
  localparam int LAST_BIT  = FIRST_BIT + SAMPLE_W - 1;
  localparam bit TDM       = (NUM_CH > 2);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] SHIFT      = 2'd2;

  logic [SYNC_STG-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                bclk_rise, lrck_edge, lrck_now, dat_bit;

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CH_W-1:0]     ch;
  logic                slot_act;
  logic                frame_start, slot_start, adv, in_win, capture, cap_last, slot_end;
  logic [CH_W-1:0]     slot_ch;
  logic [SAMPLE_W-1:0] shreg;

  logic                       vld_p1;
  logic signed [SAMPLE_W-1:0] cap_data_p1;
  logic [CH_W-1:0]            cap_ch_p1;

  logic signed [SAMPLE_W-1:0] mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]            mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       full, pop, wr_en, ovf_evt;

  // Stage 0: synchronisers; data is taken from the older stage so it is settled at the detected BCLK rise
  always_ff @(posedge clk_clk) begin
    bclk_sync <= {bclk_sync[SYNC_STG-2:0], adc_bclk};
    lrck_sync <= {lrck_sync[SYNC_STG-2:0], adc_lrck};
    dat_sync  <= {dat_sync[SYNC_STG-2:0], adc_dat};
  end

  assign bclk_rise = bclk_sync[SYNC_STG-2] & ~bclk_sync[SYNC_STG-1];
  assign lrck_now  = lrck_sync[SYNC_STG-2];
  assign lrck_edge = lrck_now ^ lrck_sync[SYNC_STG-1];
  assign dat_bit   = dat_sync[SYNC_STG-1];

  // Frame alignment: stereo waits for the ch0 (LRCK low) edge, TDM for the LRCK rise
  assign frame_start = (state == WAIT_FRAME) && enable &&
                       (TDM ? (lrck_edge & lrck_now) : (lrck_edge & ~lrck_now));
  assign slot_start  = (state == SHIFT) && enable && (TDM ? (lrck_edge & lrck_now) : lrck_edge);
  assign slot_ch     = TDM ? '0 : CH_W'(lrck_now);

  assign adv      = (state == SHIFT) && enable && slot_act && bclk_rise && !slot_start;
  assign in_win   = (bit_cnt <= CNT_W'(LAST_BIT)) && !((MODE == 0) && (bit_cnt == '0));
  assign capture  = adv && in_win;
  assign cap_last = capture && (bit_cnt == CNT_W'(LAST_BIT));
  assign slot_end = adv && (bit_cnt == CNT_W'(SLOT_BITS - 1));

  always_ff @(posedge clk_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ch       <= '0;
      slot_act <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= cap_last;
      case (state)
        IDLE: begin
          slot_act <= 1'b0;
          if (enable) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (frame_start) begin
            state    <= SHIFT;
            slot_act <= 1'b1;
            bit_cnt  <= '0;
            ch       <= '0;
          end
        end
        SHIFT: begin
          if (!enable) begin
            state    <= IDLE;
            slot_act <= 1'b0;
          end else if (slot_start) begin
            slot_act <= 1'b1;
            bit_cnt  <= '0;
            ch       <= slot_ch;
          end else if (slot_end) begin
            bit_cnt <= '0;
            // TDM advances through the frame; after the last slot, trailing BCLKs are ignored
            if (TDM && (ch != CH_W'(NUM_CH - 1))) begin
              ch <= ch + 1'b1;
            end else begin
              ch       <= '0;
              slot_act <= 1'b0;
            end
          end else if (adv) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: deserialise; a completed sample is registered with its channel for the push
  always_ff @(posedge clk_clk) begin
    if (!enable || (state != SHIFT) || slot_start) begin
      shreg <= '0;
    end else if (capture) begin
      shreg <= {shreg[SAMPLE_W-2:0], dat_bit};
    end
    if (cap_last) begin
      cap_data_p1 <= {shreg[SAMPLE_W-2:0], dat_bit};
      cap_ch_p1   <= ch;
    end
  end

  // Stage 2: FIFO write; a pop in the same cycle frees the slot for a push into a full FIFO
  assign fifo_level   = wr_ptr - rd_ptr;
  assign full         = (fifo_level == PTR_W'(FIFO_DEPTH));
  assign sample_valid = (wr_ptr != rd_ptr);
  assign pop          = sample_valid && sample_ready;
  assign wr_en        = vld_p1 && (!full || pop);
  assign ovf_evt      = vld_p1 && full && !pop;

  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem_data[wr_ptr[IDX_W-1:0]] <= cap_data_p1;
      mem_ch[wr_ptr[IDX_W-1:0]]   <= cap_ch_p1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (ovf_evt)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign sample_data = sample_valid ? mem_data[rd_ptr[IDX_W-1:0]] : '0;
  assign sample_ch   = sample_valid ? mem_ch[rd_ptr[IDX_W-1:0]]   : '0;

`ifdef AUDIO_RX_PEAK_EN
  function automatic logic [SAMPLE_W-2:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
    logic signed [SAMPLE_W-1:0] mag;
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) return '1;
    mag = x[SAMPLE_W-1] ? -x : x;
    return mag[SAMPLE_W-2:0];
  endfunction

  logic [SAMPLE_W-2:0] cap_abs;
  assign cap_abs = sat_abs(cap_data_p1);

  // Peak follows every attempted push, including ones dropped on overflow
  always_ff @(posedge clk_clk or negedge reset_reset) begin
    if (!reset_reset) begin
      peak_level <= '0;
    end else if (peak_clr) begin
      peak_level <= vld_p1 ? cap_abs : '0;
    end else if (vld_p1 && (cap_abs > peak_level)) begin
      peak_level <= cap_abs;
    end
  end
`endif

endmodule
